// File: rtl/wb_intercon_pkg.sv
// Shared definitions for the Wishbone interconnect blocks.
//   - arb_state_t : arbiter FSM encoding (ARB_IDLE, ARB_BUSY)
//   - CTI_*       : Wishbone cycle type identifiers
//   - BTE_*       : Wishbone burst type extensions
package wb_intercon_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// Combinational round-robin selector.
// Searches the request vector starting at last+1 (wrapping modulo num_req)
// and returns the first requester found.
// Ports:
//   req   in  num_req  request vector
//   last  in  iw       index of the previously served requester
//   pick  out iw       selected index (0 when nothing is requested)
//   valid out 1        at least one request present
module wb_arbiter_rr_pick #(
  parameter int num_req = 4,
  parameter int iw      = $clog2(num_req)
) (
  input  logic [num_req-1:0] req,
  input  logic [iw-1:0]      last,
  output logic [iw-1:0]      pick,
  output logic               valid
);

  always_comb begin
    int cand;
    logic [iw-1:0] cand_idx;
    pick     = '0;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // Offset 1 first so the previous owner is considered last.
    for (int k = 1; k <= num_req; k++) begin
      cand     = (int'(last) + k) % num_req;
      cand_idx = iw'(cand);
      if (!valid && req[cand_idx]) begin
        valid = 1'b1;
        pick  = cand_idx;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: num_masters masters share one slave port.
// A grant is held for the whole bus cycle (cyc high), bursts included, and
// is released only when the owning master drops cyc. One idle cycle always
// separates two grants.
// Optional feature (macro WB_ARBITER_TIMEOUT_EN): watchdog that answers a
// stalled slave with a one-cycle error after TIMEOUT_CYCLES.
// Ports:
//   wb_clk_i, wb_rst_ni               clock, asynchronous active-low reset
//   wbm_*_i                           packed master requests, master i at slot i
//   wbm_rdt_o/ack_o/err_o/rty_o       responses, granted slot only
//   wbs_*_o                           granted master's request to the slave
//   wbs_rdt_i/ack_i/err_i/rty_i       slave response
//   grant_o                           one-hot current grant (debug)
module wb_arbiter
  import wb_intercon_pkg::*;
#(
  parameter int num_masters    = 4,
  parameter int aw             = 32,
  parameter int dw             = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_ni,
  input  logic [num_masters*aw-1:0] wbm_adr_i,
  input  logic [num_masters*dw-1:0] wbm_dat_i,
  input  logic [num_masters*4-1:0]  wbm_sel_i,
  input  logic [num_masters-1:0]    wbm_we_i,
  input  logic [num_masters-1:0]    wbm_cyc_i,
  input  logic [num_masters-1:0]    wbm_stb_i,
  input  logic [num_masters*3-1:0]  wbm_cti_i,
  input  logic [num_masters*2-1:0]  wbm_bte_i,
  output logic [num_masters*dw-1:0] wbm_rdt_o,
  output logic [num_masters-1:0]    wbm_ack_o,
  output logic [num_masters-1:0]    wbm_err_o,
  output logic [num_masters-1:0]    wbm_rty_o,
  output logic [aw-1:0]             wbs_adr_o,
  output logic [dw-1:0]             wbs_dat_o,
  output logic [3:0]                wbs_sel_o,
  output logic                      wbs_we_o,
  output logic                      wbs_cyc_o,
  output logic                      wbs_stb_o,
  output logic [2:0]                wbs_cti_o,
  output logic [1:0]                wbs_bte_o,
  input  logic [dw-1:0]             wbs_rdt_i,
  input  logic                      wbs_ack_i,
  input  logic                      wbs_err_i,
  input  logic                      wbs_rty_i,
  output logic [num_masters-1:0]    grant_o
);

  localparam int IW = $clog2(num_masters);

  arb_state_t    state_reg, state_next;
  logic [IW-1:0] grant_reg, grant_next;
  logic [IW-1:0] last_reg, last_next;
  logic [IW-1:0] pick;
  logic          pick_valid;
  logic          busy;
  logic [IW-1:0] sel;
  logic          req_cyc;
  logic          req_stb;
  logic          to_hit;
  logic [num_masters-1:0] slot;

  // Unpacked views of the packed master buses, indexed by the mux select.
  logic [aw-1:0] adr_arr [num_masters];
  logic [dw-1:0] dat_arr [num_masters];
  logic [3:0]    sel_arr [num_masters];
  logic [2:0]    cti_arr [num_masters];
  logic [1:0]    bte_arr [num_masters];

  wb_arbiter_rr_pick #(
    .num_req (num_masters),
    .iw      (IW)
  ) u_pick (
    .req   (wbm_cyc_i),
    .last  (last_reg),
    .pick  (pick),
    .valid (pick_valid)
  );

  assign busy    = (state_reg == ARB_BUSY);
  // Master 0's fields are presented while idle; cyc is low then anyway.
  assign sel     = busy ? grant_reg : '0;
  assign req_cyc = wbm_cyc_i[grant_reg];
  assign req_stb = wbm_stb_i[grant_reg];

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    last_next  = last_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_next = pick;
          state_next = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // Owner released the bus: remember it so it ranks last next round.
        if (!req_cyc) begin
          last_next  = grant_reg;
          grant_next = '0;
          state_next = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_reg <= ARB_IDLE;
      grant_reg <= '0;
      last_reg  <= IW'(num_masters - 1);
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
    end
  end

`ifdef WB_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] to_cnt_reg, to_cnt_next;
  logic          any_resp;

  assign any_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
  // Counts on the raw request so the forced-low outputs do not feed back.
  assign to_hit   = busy & req_cyc & req_stb & ~any_resp & (to_cnt_reg == TO_LIMIT);

  always_comb begin
    to_cnt_next = to_cnt_reg;
    if (!busy || any_resp || to_hit) begin
      to_cnt_next = '0;
    end else if (req_cyc && req_stb) begin
      to_cnt_next = to_cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      to_cnt_reg <= '0;
    end else begin
      to_cnt_reg <= to_cnt_next;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign to_hit = 1'b0;
`endif

  // cyc follows the owner combinationally so a release is seen the same cycle.
  assign wbs_cyc_o = busy & req_cyc & ~to_hit;
  assign wbs_stb_o = busy & req_stb & ~to_hit;
  assign wbs_adr_o = adr_arr[sel];
  assign wbs_dat_o = dat_arr[sel];
  assign wbs_sel_o = sel_arr[sel];
  assign wbs_we_o  = wbm_we_i[sel];
  assign wbs_cti_o = cti_arr[sel];
  assign wbs_bte_o = bte_arr[sel];

  generate
    for (genvar gi = 0; gi < num_masters; gi++) begin : g_slot
      assign adr_arr[gi] = wbm_adr_i[gi*aw +: aw];
      assign dat_arr[gi] = wbm_dat_i[gi*dw +: dw];
      assign sel_arr[gi] = wbm_sel_i[gi*4 +: 4];
      assign cti_arr[gi] = wbm_cti_i[gi*3 +: 3];
      assign bte_arr[gi] = wbm_bte_i[gi*2 +: 2];

      // Still routed in the cycle the owner drops cyc (state is BUSY then).
      assign slot[gi]                 = busy && (grant_reg == IW'(gi));
      assign grant_o[gi]              = slot[gi];
      assign wbm_ack_o[gi]            = slot[gi] & wbs_ack_i;
      assign wbm_err_o[gi]            = slot[gi] & (wbs_err_i | to_hit);
      assign wbm_rty_o[gi]            = slot[gi] & wbs_rty_i;
      assign wbm_rdt_o[gi*dw +: dw]   = slot[gi] ? wbs_rdt_i : '0;
    end
  endgenerate

endmodule
